uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 121 ++++++++++++
 tb/tb_uart_tx.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional odd/even parity, 1 or 2 stop bits.
// state   | meaning
// S_IDLE  | line high, ready for a new byte
// S_START | start bit (low)
// S_DATA  | 8 data bits, LSB first
// S_PAR   | parity bit (only when PARITY != 0)
// S_STOP  | STOP_BITS stop bits (high), done on the final cycle
module uart_tx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       i_clock,
    input  logic       i_rst_n,
    input  logic       i_tx_dv,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_ready,
    output logic       o_tx_uart,
    output logic       o_tx_active,
    output logic       o_tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic          par_bit;
    logic          stop_idx;
    logic          bit_end;

    assign bit_end = (cnt == CNT_LAST);

    always_ff @(posedge i_clock) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            stop_idx    <= 1'b0;
            o_tx_uart   <= 1'b1;
            o_tx_ready  <= 1'b1;
            o_tx_active <= 1'b0;
            o_tx_done   <= 1'b0;
        end else begin
            o_tx_done <= 1'b0;
            if (state != S_IDLE) begin
                cnt <= bit_end ? '0 : cnt + CW'(1);
            end
            case (state)
                S_IDLE: begin
                    if (i_tx_dv) begin
                        state       <= S_START;
                        shreg       <= i_tx_byte;
                        // parity is fixed at acceptance so later byte changes cannot leak in
                        par_bit     <= (PARITY == 1) ? ~(^i_tx_byte) : ^i_tx_byte;
                        cnt         <= '0;
                        idx         <= '0;
                        stop_idx    <= 1'b0;
                        o_tx_uart   <= 1'b0;
                        o_tx_active <= 1'b1;
                        o_tx_ready  <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state     <= S_DATA;
                        o_tx_uart <= shreg[0];
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (idx == 3'd7) begin
                            if (PARITY != 0) begin
                                state     <= S_PAR;
                                o_tx_uart <= par_bit;
                            end else begin
                                state     <= S_STOP;
                                o_tx_uart <= 1'b1;
                            end
                        end else begin
                            idx       <= idx + 3'd1;
                            shreg     <= {1'b0, shreg[7:1]};
                            o_tx_uart <= shreg[1];
                        end
                    end
                end
                S_PAR: begin
                    if (bit_end) begin
                        state     <= S_STOP;
                        o_tx_uart <= 1'b1;
                    end
                end
                S_STOP: begin
                    // set one cycle early so the registered pulse lands on the last stop cycle
                    if (cnt == CNT_PRE && stop_idx == STOP_LAST) begin
                        o_tx_done <= 1'b1;
                    end
                    if (bit_end) begin
                        if (stop_idx == STOP_LAST) begin
                            state       <= S_IDLE;
                            o_tx_ready  <= 1'b1;
                            o_tx_active <= 1'b0;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances at CLKS_PER_BIT=4 covering the parity and stop-bit modes.
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk;
    logic [3:0] rst_n;
    logic [3:0] dv;
    logic [7:0] tx_byte [4];
    logic [3:0] ready, uart, active, done;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: no parity/1 stop, 1: even, 2: odd, 3: no parity/2 stop
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u0 (
        .i_clock(clk), .i_rst_n(rst_n[0]), .i_tx_dv(dv[0]), .i_tx_byte(tx_byte[0]),
        .o_tx_ready(ready[0]), .o_tx_uart(uart[0]), .o_tx_active(active[0]), .o_tx_done(done[0]));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u1 (
        .i_clock(clk), .i_rst_n(rst_n[1]), .i_tx_dv(dv[1]), .i_tx_byte(tx_byte[1]),
        .o_tx_ready(ready[1]), .o_tx_uart(uart[1]), .o_tx_active(active[1]), .o_tx_done(done[1]));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u2 (
        .i_clock(clk), .i_rst_n(rst_n[2]), .i_tx_dv(dv[2]), .i_tx_byte(tx_byte[2]),
        .o_tx_ready(ready[2]), .o_tx_uart(uart[2]), .o_tx_active(active[2]), .o_tx_done(done[2]));
    uart_tx #(.CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2)) u3 (
        .i_clock(clk), .i_rst_n(rst_n[3]), .i_tx_dv(dv[3]), .i_tx_byte(tx_byte[3]),
        .o_tx_ready(ready[3]), .o_tx_uart(uart[3]), .o_tx_active(active[3]), .o_tx_done(done[3]));

    // exp bit i is the i-th serial bit on the line (bit 0 = start bit)
    typedef struct {
        int          k;
        logic [7:0]  b;
        logic [11:0] exp;
        int          nbits;
        string       name;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_check(input int k, input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            dv[k] = 1'b0;
            chk({nm, " idle_line"},   uart[k],   1'b1);
            chk({nm, " idle_active"}, active[k], 1'b0);
            chk({nm, " idle_ready"},  ready[k],  1'b1);
            chk({nm, " idle_done"},   done[k],   1'b0);
        end
    endtask

    // p1/p2: frame cycles in which a stray request with 0xFF is issued; abort_c: cycle reset is asserted
    task automatic frame(input int k, input logic [7:0] b, input logic [11:0] exp, input int nbits,
                         input string nm, input int p1, input int p2, input int abort_c);
        int n;
        int last;
        n    = nbits * CPB;
        last = (abort_c != 0) ? abort_c : n;
        @(negedge clk);
        chk({nm, " pre_ready"}, ready[k], 1'b1);
        chk({nm, " pre_line"},  uart[k],  1'b1);
        dv[k]      = 1'b1;
        tx_byte[k] = b;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            dv[k]      = 1'b0;
            tx_byte[k] = ~b;
            chk($sformatf("%s line c%0d", nm, c),   uart[k],   exp[(c-1)/CPB]);
            chk($sformatf("%s active c%0d", nm, c), active[k], 1'b1);
            chk($sformatf("%s ready c%0d", nm, c),  ready[k],  1'b0);
            chk($sformatf("%s done c%0d", nm, c),   done[k],   (c == n) ? 1'b1 : 1'b0);
            if (c == p1 || c == p2) begin
                dv[k]      = 1'b1;
                tx_byte[k] = 8'hFF;
            end
            if (c == abort_c) rst_n[k] = 1'b0;
        end
        if (abort_c != 0) begin
            @(negedge clk);
            rst_n[k] = 1'b1;
            chk({nm, " abort_line"},   uart[k],   1'b1);
            chk({nm, " abort_ready"},  ready[k],  1'b1);
            chk({nm, " abort_active"}, active[k], 1'b0);
            chk({nm, " abort_done"},   done[k],   1'b0);
        end
    endtask

    initial begin
        tbl[0] = '{0, 8'h55, 12'h2AA, 10, "x55_p0"};
        tbl[1] = '{1, 8'hA7, 12'h74E, 11, "xA7_even"};
        tbl[2] = '{2, 8'hA7, 12'h54E, 11, "xA7_odd"};
        tbl[3] = '{3, 8'h00, 12'h600, 11, "x00_s2"};
        tbl[4] = '{1, 8'hFF, 12'h5FE, 11, "xFF_even"};
        tbl[5] = '{2, 8'h01, 12'h402, 11, "x01_odd"};
        tbl[6] = '{3, 8'hC3, 12'h786, 11, "xC3_s2"};
        tbl[7] = '{2, 8'h81, 12'h702, 11, "x81_odd"};

        rst_n = 4'b0000;
        dv    = 4'b0000;
        for (int i = 0; i < 4; i++) tx_byte[i] = 8'h00;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_line%0d", i),   uart[i],   1'b1);
            chk($sformatf("reset_ready%0d", i),  ready[i],  1'b1);
            chk($sformatf("reset_active%0d", i), active[i], 1'b0);
            chk($sformatf("reset_done%0d", i),   done[i],   1'b0);
        end
        rst_n = 4'b1111;
        for (int i = 0; i < 4; i++) idle_check(i, 1, "post_reset");

        for (int i = 0; i < 8; i++) begin
            frame(tbl[i].k, tbl[i].b, tbl[i].exp, tbl[i].nbits, tbl[i].name, 0, 0, 0);
            idle_check(tbl[i].k, 2, tbl[i].name);
        end

        // stray requests during data bit 2 and in the done cycle
        frame(0, 8'h3C, 12'h278, 10, "x3C_ignore", 14, 40, 0);
        idle_check(0, 12, "x3C_no_second");

        // reset during data bit 3, then a clean frame
        frame(0, 8'h81, 12'h302, 10, "x81_abort", 0, 0, 18);
        idle_check(0, 44, "x81_after_abort");
        frame(0, 8'h42, 12'h284, 10, "x42_after", 0, 0, 0);
        idle_check(0, 2, "x42_after");

        // reset wins over a simultaneous request
        @(negedge clk);
        rst_n[0]   = 1'b0;
        dv[0]      = 1'b1;
        tx_byte[0] = 8'h99;
        @(negedge clk);
        rst_n[0] = 1'b1;
        dv[0]    = 1'b0;
        chk("rst_prio_line",  uart[0],  1'b1);
        chk("rst_prio_ready", ready[0], 1'b1);
        idle_check(0, 8, "rst_prio");

        // back-to-back: the second frame's pre-check is the single idle-high cycle
        frame(0, 8'h12, 12'h224, 10, "x12_b2b", 0, 0, 0);
        frame(0, 8'h34, 12'h268, 10, "x34_b2b", 0, 0, 0);
        idle_check(0, 2, "x34_b2b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
